scfetch: RTL and testbench
==========================

Name: scfetch

Overview:
- Instruction fetch stage of the single-cycle CPU, upstream of the instruction ROM and decode.
- Holds the program counter and drives the ROM read address.
- Captures each returned word with its PC into a small in-order queue.
- Presents queue entries to decode through a valid/ready handshake. A redirect from execute (branch or jump) flushes the queue and reloads the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, queue entries; power of two, >= 2.
- PTR_W, 1, log2(DEPTH); index width of the queue pointers.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- imem_addr  output  32  byte address to the instruction ROM; the ROM uses word index [11:2].
- imem_inst  input  32  instruction word from the ROM; combinational in imem_addr, valid in the same cycle.
- redirect  input  1  flush and reload the PC this cycle.
- redirect_pc  input  32  new PC; bits [1:0] are ignored and forced to 0.
- out_valid  output  1  queue head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_inst  output  32  instruction at the queue head.
- out_pc  output  32  PC of the head instruction.

Behaviour:
- Reset (clk edge with rst=1):
  - pc <= RESET_PC; count, rd_ptr and wr_ptr <= 0.
  - During and after the reset edge: out_valid=0 and imem_addr=RESET_PC.
  - out_inst and out_pc read 0 while empty; queue storage is cleared at reset.
  - rst overrides redirect and all handshakes. A reset mid-stream discards every queued entry.
- imem_addr is pc, combinational from the register. No other logic sits in that path.
- Signals (evaluated each cycle, rst=0):
  - full = (count == DEPTH)
  - push = !full && !redirect
  - pop = out_valid && out_ready && !redirect
- push:
  - Write {pc, imem_inst} at wr_ptr.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
  - pc <= pc + 4, 32-bit unsigned; 32'hFFFF_FFFC wraps to 0.
- Stall: when !push and !redirect, pc holds.
- pop: rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Count update:
  - push and pop together: count unchanged.
  - push only: +1.
  - pop only: -1.
- full is taken from the registered count. When full, there is no push even if a pop occurs that cycle; the push resumes the next cycle.
- Steady state with out_ready held high: count=1, one instruction per cycle.
- redirect (rst=0) takes priority over push and pop:
  - count, rd_ptr and wr_ptr <= 0; pc <= {redirect_pc[31:2], 2'b00}.
  - The head shown that cycle is not consumed, even if out_ready=1; decode must treat it as killed.
  - No fetch occurs in the redirect cycle.
- Latency:
  - Redirect or reset at edge N: the target word is fetched during cycle N+1 and is at the head, out_valid=1, after edge N+1.
  - Redirect penalty is 1 bubble cycle.
- out_valid = (count != 0). out_inst and out_pc are the entry at rd_ptr, driven combinationally from storage.
- Empty with out_ready=1: no pop, no underflow; count stays 0.
- Back-to-back redirects: each one reloads the PC, and only the last one's target is fetched.

Decomposition:
- Shared include sc_defs.vh:
  - INST_W=32, ADDR_W=32
  - `SC_RESET_PC`
  - PC_STEP=4
  - Shared with the decode and execute stages.
- One natural sub-module, scfetch_queue: a synchronous FIFO with flush, DEPTH x 64 bits, exposing push/pop/flush/count.
- scfetch keeps the PC, the push/pop/redirect arbitration and the ROM interface.

Test Plan:
1. Reset then free-run: rst high 2 cycles with RESET_PC=0, ROM word i = 32'h1000_0000+i, out_ready=1 -> out_valid rises after the first post-reset edge; out_pc sequence 0,4,8,12 on consecutive cycles; out_inst matches 32'h1000_0000..32'h1000_0003; imem_addr leads out_pc by 4.
2. Backpressure and full: out_ready=0 for 5 cycles -> count reaches 2, then pc holds at 8 and imem_addr=8. Set out_ready=1 -> heads 0,4 pop, then 8 follows with no gap or duplicate.
3. Redirect with a valid head: redirect=1, redirect_pc=32'h0000_0043, out_ready=1, head pc=4 -> pc=4 is not counted as accepted; next cycle out_valid=0; following cycle out_pc=32'h40 with out_inst=ROM[16].
4. Simultaneous push/pop at pointer wrap: DEPTH=2 steady stream over 10 instructions -> count stays 1 and no entry is dropped or repeated across the rd_ptr/wr_ptr wraps.
5. PC wrap: redirect_pc=32'hFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
6. Reset mid-operation: queue full (count=2), assert rst together with redirect=1, redirect_pc=32'h80 -> out_valid=0 next cycle; after release, first out_pc=RESET_PC, not 32'h80.

Source files
------------

// File: rtl/scfetch_pkg.sv
// Shared fetch-stage definitions: word/address widths, reset PC, PC step,
// the queue entry layout and PC alignment.
package scfetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ENTRY_W = INST_W + ADDR_W;

  localparam logic [ADDR_W-1:0] SC_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_STEP     = 32'd4;

  // One queued fetch: the PC in the upper half, the instruction word in the lower half.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so that every PC is word aligned.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/scfetch_queue.sv
// In-order fetch queue: DEPTH entries of {pc, inst}, synchronous flush.
// Storage is cleared on reset; flush only rewinds pointers and count.
module scfetch_queue
  import scfetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer, count and storage update; flush beats push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fetch_entry_t'(wdata);
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head entry straight from storage.
  always_comb begin
    rdata = mem[rd_ptr];
  end

endmodule

// File: rtl/scfetch.sv
// Instruction fetch stage: owns the PC, drives the ROM address, queues
// returned words with their PC, and hands them to decode via valid/ready.
// A redirect flushes the queue and reloads the PC.
module scfetch
  import scfetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = SC_RESET_PC,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PTR_W    = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [PTR_W:0]    count;
  logic              full;
  logic              push;
  logic              pop;
  fetch_entry_t      wr_entry;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t      head;

  // Program counter: reset, then redirect, then advance on every fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_pc(redirect_pc);
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  // Fetch/consume arbitration; full comes from the registered count so a
  // pop in a full cycle does not also allow a push.
  always_comb begin
    full     = (count == CNT_FULL);
    push     = !full && !redirect;
    pop      = out_valid && out_ready && !redirect;
    wr_entry = '{pc: pc, inst: imem_inst};
  end

  scfetch_queue #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head_raw),
    .count (count)
  );

  // ROM address and decode-facing outputs; head fields read 0 while empty.
  always_comb begin
    imem_addr = pc;
    head      = fetch_entry_t'(head_raw);
    out_valid = (count != '0);
    out_inst  = out_valid ? head.inst : '0;
    out_pc    = out_valid ? head.pc   : '0;
  end

endmodule

// File: tb/tb_scfetch.sv
// Directed bench for scfetch: a vector table covering free-run,
// backpressure, redirect and back-to-back redirects, then hand sequences
// for pointer wrap streaming, PC wrap and reset-over-redirect.
module tb_scfetch;

  typedef struct {
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int tests  = 0;
  int errors = 0;

  vec_t vecs [32];
  int   nvec = 0;

  always #5 clk = ~clk;

  // ROM: word index [11:2] mapped to 32'h1000_0000 + index.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + {22'd0, a[11:2]};
  endfunction

  assign imem_inst = rom(imem_addr);

  scfetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2),
    .PTR_W    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc)
  );

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic ev, input logic [31:0] epc,
                              input logic [31:0] eaddr);
    vec_t v;
    v.rst         = r;
    v.redirect    = rd;
    v.redirect_pc = rpc;
    v.ready       = rdy;
    v.exp_valid   = ev;
    v.exp_pc      = ev ? epc : 32'h0;
    v.exp_inst    = ev ? rom(epc) : 32'h0;
    v.exp_addr    = eaddr;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nvec] = v;
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected values describe the state seen during this cycle; the inputs
  // take effect at the following rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    rst         = v.rst;
    redirect    = v.redirect;
    redirect_pc = v.redirect_pc;
    out_ready   = v.ready;
    @(negedge clk);
    check({tag, " valid"}, {31'd0, out_valid}, {31'd0, v.exp_valid});
    check({tag, " pc"},    out_pc,    v.exp_pc);
    check({tag, " inst"},  out_inst,  v.exp_inst);
    check({tag, " addr"},  imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset then free-run (second reset cycle in row 0).
    add(mk(1, 0, 0,     1, 0, 0,     32'h0));
    add(mk(0, 0, 0,     1, 0, 0,     32'h0));
    add(mk(0, 0, 0,     1, 1, 0,     32'h4));
    add(mk(0, 0, 0,     1, 1, 4,     32'h8));
    add(mk(0, 0, 0,     1, 1, 8,     32'hC));
    // Reset, then backpressure for 5 cycles, then drain.
    add(mk(1, 0, 0,     0, 1, 12,    32'h10));
    add(mk(0, 0, 0,     0, 0, 0,     32'h0));
    add(mk(0, 0, 0,     0, 1, 0,     32'h4));
    add(mk(0, 0, 0,     0, 1, 0,     32'h8));
    add(mk(0, 0, 0,     0, 1, 0,     32'h8));
    add(mk(0, 0, 0,     0, 1, 0,     32'h8));
    add(mk(0, 0, 0,     1, 1, 0,     32'h8));
    add(mk(0, 0, 0,     1, 1, 4,     32'h8));
    // Reset, then redirect to 0x43 while head pc=4 is offered.
    add(mk(1, 0, 0,     1, 1, 8,     32'hC));
    add(mk(0, 0, 0,     1, 0, 0,     32'h0));
    add(mk(0, 0, 0,     1, 1, 0,     32'h4));
    add(mk(0, 1, 32'h43, 1, 1, 4,    32'h8));
    add(mk(0, 0, 0,     1, 0, 0,     32'h40));
    add(mk(0, 0, 0,     1, 1, 32'h40, 32'h44));
    // Back-to-back redirects: only the last target is fetched.
    add(mk(0, 1, 32'h100, 1, 1, 32'h44, 32'h48));
    add(mk(0, 1, 32'h203, 1, 0, 0,    32'h100));
    add(mk(0, 0, 0,     1, 0, 0,     32'h200));
    add(mk(0, 0, 0,     1, 1, 32'h200, 32'h204));

    for (int i = 0; i < nvec; i++) begin
      run_vec(vecs[i], $sformatf("row%0d", i));
    end

    // Steady stream across several pointer wraps.
    run_vec(mk(0, 1, 32'h300, 1, 1, 32'h204, 32'h208), "wrap redirect");
    run_vec(mk(0, 0, 0, 1, 0, 0, 32'h300), "wrap bubble");
    for (int i = 0; i < 10; i++) begin
      run_vec(mk(0, 0, 0, 1, 1, 32'h300 + 4 * i, 32'h304 + 4 * i),
              $sformatf("stream%0d", i));
    end

    // PC wraps from FFFF_FFFC to 0.
    run_vec(mk(0, 1, 32'hFFFF_FFF8, 1, 1, 32'h328, 32'h32C), "pcwrap redirect");
    run_vec(mk(0, 0, 0, 1, 0, 0, 32'hFFFF_FFF8), "pcwrap bubble");
    run_vec(mk(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC), "pcwrap0");
    run_vec(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0), "pcwrap1");
    run_vec(mk(0, 0, 0, 1, 1, 32'h0, 32'h4), "pcwrap2");

    // Fill the queue, then reset together with a redirect.
    run_vec(mk(0, 1, 32'h500, 0, 1, 32'h4, 32'h8), "rstmid redirect");
    run_vec(mk(0, 0, 0, 0, 0, 0, 32'h500), "rstmid fill0");
    run_vec(mk(0, 0, 0, 0, 1, 32'h500, 32'h504), "rstmid fill1");
    run_vec(mk(0, 0, 0, 0, 1, 32'h500, 32'h508), "rstmid full");
    run_vec(mk(1, 1, 32'h80, 1, 1, 32'h500, 32'h508), "rstmid assert");
    run_vec(mk(0, 0, 0, 1, 0, 0, 32'h0), "rstmid empty");
    run_vec(mk(0, 0, 0, 1, 1, 32'h0, 32'h4), "rstmid first");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
